// File: rtl/axi_slice_dc_pkg.sv
// rtl/axi_slice_dc_pkg.sv - shared types for the dual-clock slice isolation controller
package axi_slice_dc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2,
    WAKE     = 2'd3
  } iso_state_e;

endpackage

// File: rtl/axi_slice_dc_outstanding_cnt.sv
// rtl/axi_slice_dc_outstanding_cnt.sv - outstanding-transaction counter with clear
module axi_slice_dc_outstanding_cnt #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 full,
  output logic                 empty
);

  assign full  = &cnt;
  assign empty = (cnt == '0);

  // Simultaneous inc/dec cancel; a stray dec at zero or inc at full is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end else if (dec && !inc && !empty) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axi_slice_dc_isolate_ctrl.sv
// rtl/axi_slice_dc_isolate_ctrl.sv - drains outstanding AXI traffic and sequences slice isolation
module axi_slice_dc_isolate_ctrl
  import axi_slice_dc_pkg::*;
#(
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic isolate_req_i,
  output logic isolate_ack_o,
  output logic isolate_o,
  output logic timeout_o,
  output logic aw_block_o,
  output logic ar_block_o,
  input  logic aw_valid_i,
  input  logic aw_ready_i,
  input  logic ar_valid_i,
  input  logic ar_ready_i,
  input  logic b_valid_i,
  input  logic b_ready_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);

  iso_state_e           state;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 iso_q;
  logic                 timeout_q;

  logic [CNT_WIDTH-1:0] wr_cnt, rd_cnt;
  logic                 wr_full, wr_empty, rd_full, rd_empty;
  logic                 aw_hs, b_hs, ar_hs, r_done;
  logic                 wr_idle_next, rd_idle_next;
  logic                 drain_done, drain_tmo, force_clr;

  assign aw_hs  = aw_valid_i & aw_ready_i;
  assign b_hs   = b_valid_i & b_ready_i;
  assign ar_hs  = ar_valid_i & ar_ready_i;
  assign r_done = r_valid_i & r_ready_i & r_last_i;

  // Drain completion looks at the counter values about to be registered.
  assign wr_idle_next = (wr_empty & ~(aw_hs & ~b_hs)) |
                        ((wr_cnt == CNT_WIDTH'(1)) & b_hs & ~aw_hs);
  assign rd_idle_next = (rd_empty & ~(ar_hs & ~r_done)) |
                        ((rd_cnt == CNT_WIDTH'(1)) & r_done & ~ar_hs);
  assign drain_done   = wr_idle_next & rd_idle_next;
  assign drain_tmo    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
  assign force_clr    = (state == DRAIN) & ~drain_done & drain_tmo;

  axi_slice_dc_outstanding_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (aw_hs),
    .dec   (b_hs),
    .clr   (force_clr),
    .cnt   (wr_cnt),
    .full  (wr_full),
    .empty (wr_empty)
  );

  axi_slice_dc_outstanding_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (ar_hs),
    .dec   (r_done),
    .clr   (force_clr),
    .cnt   (rd_cnt),
    .full  (rd_full),
    .empty (rd_empty)
  );

  assign aw_block_o    = (state != RUN) | wr_full;
  assign ar_block_o    = (state != RUN) | rd_full;
  assign isolate_o     = iso_q;
  assign isolate_ack_o = iso_q;
  assign timeout_o     = timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      tmo_cnt   <= '0;
      iso_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (isolate_req_i) begin
            state     <= DRAIN;
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
          end
        end
        DRAIN: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (drain_done) begin
            state <= ISOLATED;
            iso_q <= 1'b1;
          end else if (drain_tmo) begin
            state     <= ISOLATED;
            iso_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ISOLATED: begin
          if (!isolate_req_i) begin
            state <= WAKE;
            iso_q <= 1'b0;
          end
        end
        WAKE: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
          iso_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slice_dc_isolate_ctrl.sv
// tb/tb_axi_slice_dc_isolate_ctrl.sv - self-checking bench for the slice isolation controller
module tb_axi_slice_dc_isolate_ctrl;

  localparam int CW   = 2;
  localparam int TMO  = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, isolate_req_i;
  logic isolate_ack_o, isolate_o, timeout_o, aw_block_o, ar_block_o;
  logic aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
  logic b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;

  axi_slice_dc_isolate_ctrl #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .isolate_req_i (isolate_req_i),
    .isolate_ack_o (isolate_ack_o),
    .isolate_o     (isolate_o),
    .timeout_o     (timeout_o),
    .aw_block_o    (aw_block_o),
    .ar_block_o    (ar_block_o),
    .aw_valid_i    (aw_valid_i),
    .aw_ready_i    (aw_ready_i),
    .ar_valid_i    (ar_valid_i),
    .ar_ready_i    (ar_ready_i),
    .b_valid_i     (b_valid_i),
    .b_ready_i     (b_ready_i),
    .r_valid_i     (r_valid_i),
    .r_ready_i     (r_ready_i),
    .r_last_i      (r_last_i)
  );

  int total = 0;
  int bad   = 0;

  // Reference: phase 0 running, 1 draining, 2 isolated, 3 waking.
  int m_phase = 0;
  int m_wr    = 0;
  int m_rd    = 0;
  int m_drain = 0;
  bit m_tout  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_aw_closed();
    return (m_phase != 0) || (m_wr == MAXC);
  endfunction

  function automatic bit m_ar_closed();
    return (m_phase != 0) || (m_rd == MAXC);
  endfunction

  task automatic step(input bit rst, input bit req,
                      input bit awv, input bit awr, input bit arv, input bit arr,
                      input bit bv, input bit br, input bit rv, input bit rr, input bit rl);
    int nwr, nrd;
    @(negedge clk);
    chk("isolate",  isolate_o,     m_phase == 2);
    chk("ack",      isolate_ack_o, m_phase == 2);
    chk("timeout",  timeout_o,     m_tout);
    chk("aw_block", aw_block_o,    m_aw_closed());
    chk("ar_block", ar_block_o,    m_ar_closed());
    rst_i         = rst;
    isolate_req_i = req;
    aw_valid_i    = awv & ~m_aw_closed();
    aw_ready_i    = awr;
    ar_valid_i    = arv & ~m_ar_closed();
    ar_ready_i    = arr;
    b_valid_i     = bv;
    b_ready_i     = br;
    r_valid_i     = rv;
    r_ready_i     = rr;
    r_last_i      = rl;
    if (rst) begin
      m_phase = 0; m_wr = 0; m_rd = 0; m_drain = 0; m_tout = 1'b0;
    end else begin
      nwr = m_wr + int'(aw_valid_i & awr) - int'(bv & br);
      nrd = m_rd + int'(ar_valid_i & arr) - int'(rv & rr & rl);
      if (nwr < 0) nwr = 0;
      if (nrd < 0) nrd = 0;
      case (m_phase)
        0: if (req) begin m_phase = 1; m_drain = 0; m_tout = 1'b0; end
        1: begin
          m_drain++;
          if (nwr == 0 && nrd == 0) m_phase = 2;
          else if (m_drain == TMO) begin
            m_phase = 2; m_tout = 1'b1; nwr = 0; nrd = 0;
          end
        end
        2: if (!req) m_phase = 3;
        default: m_phase = 0;
      endcase
      m_wr = nwr;
      m_rd = nrd;
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit req, input int n);
    for (int i = 0; i < n; i++) step(0, req, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic aw(input bit req);        step(0, req, 1, 1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ar(input bit req);        step(0, req, 0, 0, 1, 1, 0, 0, 0, 0, 0); endtask
  task automatic b(input bit req);         step(0, req, 0, 0, 0, 0, 1, 1, 0, 0, 0); endtask
  task automatic r(input bit req, input bit last); step(0, req, 0, 0, 0, 0, 0, 0, 1, 1, last); endtask

  initial begin
    bit req;
    rst_i = 1'b1; isolate_req_i = 1'b0;
    aw_valid_i = 1'b0; aw_ready_i = 1'b0; ar_valid_i = 1'b0; ar_ready_i = 1'b0;
    b_valid_i = 1'b0; b_ready_i = 1'b0; r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iso", isolate_o, 0);
    chk("rst_ack", isolate_ack_o, 0);
    chk("rst_tmo", timeout_o, 0);
    chk("rst_awb", aw_block_o, 0);
    chk("rst_arb", ar_block_o, 0);

    // Idle isolation and release latency
    idle(0, 8);
    idle(1, 1); #1 chk("idle_drain_iso", isolate_o, 0); chk("idle_drain_blk", aw_block_o, 1);
    idle(1, 1); #1 chk("idle_iso", isolate_o, 1); chk("idle_ack", isolate_ack_o, 1);
    idle(1, 6);
    idle(0, 1); #1 chk("wake_iso", isolate_o, 0); chk("wake_blk", aw_block_o, 1);
    idle(0, 1); #1 chk("run_blk", aw_block_o, 0);

    // Saturation then write drain
    aw(0); aw(0); aw(0);
    #1 chk("sat_awb", aw_block_o, 1); chk("sat_arb", ar_block_o, 0);
    b(0); #1 chk("unsat_awb", aw_block_o, 0);
    aw(0);
    idle(1, 2); #1 chk("wdrain_iso", isolate_o, 0); chk("wdrain_blk", aw_block_o, 1);
    b(1); b(1); #1 chk("wdrain_wait", isolate_o, 0);
    b(1); #1 chk("wdrain_done", isolate_o, 1); chk("wdrain_tmo", timeout_o, 0);
    idle(0, 2);

    // Same-cycle AW+B, then completion coinciding with the timeout cycle
    aw(0);
    step(0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    aw(0); #1 chk("simul_wr2", aw_block_o, 0);
    aw(0); #1 chk("simul_wr3", aw_block_o, 1);
    b(0); b(0);
    idle(1, 8);
    #1 chk("race_pending", isolate_o, 0);
    b(1); #1 chk("race_iso", isolate_o, 1); chk("race_tmo", timeout_o, 0);
    idle(0, 2);

    // Read bursts, only last beats retire
    ar(0); ar(0);
    idle(1, 1);
    r(1, 0); r(1, 1); #1 chk("rd_one_left", isolate_o, 0);
    r(1, 0); r(1, 0); #1 chk("rd_mid_burst", isolate_o, 0);
    r(1, 1); #1 chk("rd_done", isolate_o, 1); chk("rd_tmo", timeout_o, 0);
    idle(0, 2);

    // Forced isolation by timeout, then reset mid-drain
    aw(0);
    idle(1, 8); #1 chk("tmo_pending", isolate_o, 0);
    idle(1, 1); #1 chk("tmo_iso", isolate_o, 1); chk("tmo_flag", timeout_o, 1);
    idle(0, 2); #1 chk("tmo_sticky", timeout_o, 1); chk("tmo_wr_clr", aw_block_o, 0);
    aw(0); aw(0); #1 chk("tmo_wr2", aw_block_o, 0);
    idle(1, 2);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst2_iso", isolate_o, 0);
    chk("rst2_tmo", timeout_o, 0);
    chk("rst2_awb", aw_block_o, 0);
    chk("rst2_arb", ar_block_o, 0);
    idle(0, 2);

    // Randomized traffic against the reference
    req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) req = ~req;
      step($urandom_range(399) == 0, req,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(3) == 0, 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
